cache_fill: RTL and testbench

Memory-side fill engine placed directly downstream of the cache's miss port. It accepts the cache's held `address_enable`/`address` miss request and performs one word read on an Avalon-MM-style pipelined read master with `waitrequest`/`readdatavalid`. It returns the word to the cache as a one-cycle `data_valid` pulse that is qualified against the still-requested address. Stuck transfers are aborted by a watchdog.

---
 rtl/cache_fill_pkg.sv | 13 +
 rtl/cache_fill.sv | 116 +++++++++++
 tb/tb_cache_fill.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_pkg.sv
// Shared types for the cache fill engine: register word and fill FSM state encoding.
package cache_fill_pkg;

    typedef logic [31:0] regval_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } fill_state_t;

endpackage

// File: rtl/cache_fill.sv
// Single-word fill engine between the cache miss port and a pipelined read master,
// with a watchdog that aborts transfers the memory never completes.
module cache_fill
    import cache_fill_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 24,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  address_enable_i,
    input  regval_t               address_i,
    output logic                  data_valid_o,
    output regval_t               data_o,
    output logic                  mem_read_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    input  logic                  mem_waitrequest_i,
    input  logic                  mem_readdatavalid_i,
    input  regval_t               mem_readdata_i,
    output logic                  busy_o,
    output logic                  timeout_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES);

    fill_state_t           state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  mem_read_q, mem_read_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    regval_t               data_q, data_d;
    logic                  timeout_q, timeout_d;

    logic [ADDR_WIDTH-1:0] req_word;
    logic                  unused_addr_bits;
    logic                  in_flight;
    logic                  data_arrives;

    assign req_word         = address_i[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{address_i[31:ADDR_WIDTH+2], address_i[1:0]};

    assign in_flight    = (state_q == StIssue) || (state_q == StWait);
    // Data only counts once the request has been accepted (or on the accepting edge itself).
    assign data_arrives = mem_readdatavalid_i &&
                          ((state_q == StWait) || (state_q == StIssue && !mem_waitrequest_i));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_read_d    = mem_read_q;
        mem_address_d = mem_address_q;
        data_d        = data_q;
        timeout_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (address_enable_i) begin
                    mem_address_d = req_word;
                    mem_read_d    = 1'b1;
                    cnt_d         = '0;
                    state_d       = StIssue;
                end
            end
            StIssue, StWait: begin
                cnt_d = cnt_q + CntW'(1);
                // A completion on the watchdog's final cycle is still delivered.
                if (data_arrives) begin
                    mem_read_d = 1'b0;
                    data_d     = mem_readdata_i;
                    state_d    = StDone;
                end else if (cnt_d == CntLimit) begin
                    mem_read_d = 1'b0;
                    timeout_d  = 1'b1;
                    state_d    = StIdle;
                end else if (state_q == StIssue && !mem_waitrequest_i) begin
                    mem_read_d = 1'b0;
                    state_d    = StWait;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d    = StIdle;
                mem_read_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            data_q        <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            data_q        <= data_d;
            timeout_q     <= timeout_d;
        end
    end

    assign mem_read_o    = mem_read_q;
    assign mem_address_o = mem_address_q;
    assign data_o        = data_q;
    assign timeout_o     = timeout_q;
    assign busy_o        = (state_q != StIdle) || in_flight;
    assign data_valid_o  = (state_q == StDone) && address_enable_i &&
                           (req_word == mem_address_q);

endmodule

// File: tb/tb_cache_fill.sv
// Randomized bench for cache_fill: memory responder with random stalls and latencies,
// checked every cycle against a transfer-level timing model.
module tb_cache_fill;
    import cache_fill_pkg::*;

    localparam int unsigned AW      = 24;
    localparam int unsigned TIMEOUT = 8;

    logic          clock;
    logic          reset_n;
    logic          address_enable;
    regval_t       address;
    logic          data_valid;
    regval_t       data;
    logic          mem_read;
    logic [AW-1:0] mem_address;
    logic          mem_waitrequest;
    logic          mem_readdatavalid;
    regval_t       mem_readdata;
    logic          busy;
    logic          timeout;

    int n_cmp = 0;
    int n_err = 0;
    regval_t exp_data = '0;

    cache_fill #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) u_dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .address_enable_i   (address_enable),
        .address_i          (address),
        .data_valid_o       (data_valid),
        .data_o             (data),
        .mem_read_o         (mem_read),
        .mem_address_o      (mem_address),
        .mem_waitrequest_i  (mem_waitrequest),
        .mem_readdatavalid_i(mem_readdatavalid),
        .mem_readdata_i     (mem_readdata),
        .busy_o             (busy),
        .timeout_o          (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", tag, $time, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".mem_read"}, 32'(mem_read), 32'd0);
        check({tag, ".data_valid"}, 32'(data_valid), 32'd0);
        check({tag, ".timeout"}, 32'(timeout), 32'd0);
        check({tag, ".data"}, data, exp_data);
    endtask

    // One miss: the request is sampled at edge E0; the memory accepts at E(stall+1) and returns
    // data lat edges later, so n = stall+1+lat cycles are spent in flight before DONE at cycle n.
    // mode 1: address switches to alt once the request is accepted; 2: cache abandons the miss;
    // 3: only ignored address bits change.
    task automatic run_txn(input regval_t addr, input int stall, input int lat,
                           input regval_t rdata, input int mode, input regval_t alt);
        int      n;
        int      last;
        bit      to;
        bit      exp_dv;
        regval_t cur_addr;
        bit      cur_en;
        logic [AW-1:0] word;

        n        = stall + 1 + lat;
        to       = (n > TIMEOUT);
        last     = to ? TIMEOUT : n;
        word     = addr[AW+1:2];
        cur_addr = addr;
        cur_en   = 1'b1;

        address_enable    = 1'b1;
        address           = addr;
        mem_waitrequest   = (stall > 0);
        mem_readdatavalid = 1'($urandom_range(0, 1));
        mem_readdata      = $urandom;

        for (int c = 0; c <= last; c++) begin
            step();
            if (c == n && !to) exp_data = rdata;
            exp_dv = !to && (c == n) && cur_en && (cur_addr[AW+1:2] == word);
            check("mem_read", 32'(mem_read), 32'((c <= stall) && (c < int'(TIMEOUT))));
            check("mem_address", 32'(mem_address), 32'(word));
            check("busy", 32'(busy), 32'(c < last || !to));
            check("data_valid", 32'(data_valid), 32'(exp_dv));
            check("timeout", 32'(timeout), 32'(to && c == int'(TIMEOUT)));
            check("data", data, exp_data);

            mem_waitrequest   = (c + 1 <= stall);
            mem_readdatavalid = (c + 1 == n) ||
                                ((c < stall || c >= n) && ($urandom_range(0, 1) == 1));
            mem_readdata      = (c + 1 == n) ? rdata : $urandom;
            if (c == stall) begin
                case (mode)
                    1: begin address = alt; cur_addr = alt; end
                    2: begin address_enable = 1'b0; cur_en = 1'b0; end
                    3: begin address = addr ^ 32'hFC00_0003; cur_addr = address; end
                    default: ;
                endcase
            end
            if (c == last) address_enable = 1'b0;
        end

        step();
        check_idle_outputs("post");
        check("post.mem_address", 32'(mem_address), 32'(word));
        mem_waitrequest   = 1'($urandom_range(0, 1));
        mem_readdatavalid = 1'($urandom_range(0, 1));
        mem_readdata      = $urandom;
    endtask

    initial begin
        reset_n           = 1'b0;
        address_enable    = 1'b0;
        address           = '0;
        mem_waitrequest   = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;

        step();
        step();
        check_idle_outputs("reset");
        check("reset.mem_address", 32'(mem_address), 32'd0);
        reset_n = 1'b1;
        step();
        check_idle_outputs("after_reset");

        // No stall, one-cycle read latency.
        run_txn(32'h0000_0104, 0, 1, 32'hDEAD_BEEF, 0, '0);
        check("plan.word_0x104", 32'(mem_address), 32'h41);
        check("plan.data_beef", data, 32'hDEAD_BEEF);
        // Four stall cycles.
        run_txn(32'h0000_0208, 4, 1, 32'hCAFE_F00D, 0, '0);
        // Accept with data on the same edge.
        run_txn(32'h0000_0310, 0, 0, 32'h1234_5678, 0, '0);
        check("plan.data_5678", data, 32'h1234_5678);
        // Memory never answers; one stuck in WAIT, one stuck in ISSUE.
        run_txn(32'h0000_0400, 0, 40, 32'h0BAD_0BAD, 0, '0);
        run_txn(32'h0000_0404, 20, 0, 32'h0BAD_0BAD, 0, '0);
        mem_readdatavalid = 1'b1;
        mem_readdata      = 32'h5555_AAAA;
        address_enable    = 1'b0;
        step();
        mem_readdatavalid = 1'b0;
        check_idle_outputs("late_rdv");
        // Completion on the watchdog's last cycle.
        run_txn(32'h0000_0500, 3, 4, 32'h0F0F_0F0F, 0, '0);
        // Address moves during WAIT, then the new address is fetched.
        run_txn(32'h0000_0100, 0, 3, 32'h1111_2222, 1, 32'h0000_0200);
        run_txn(32'h0000_0200, 0, 1, 32'h3333_4444, 0, '0);
        check("plan.word_0x200", 32'(mem_address), 32'h80);

        // Reset during WAIT.
        address_enable  = 1'b1;
        address         = 32'h0000_0300;
        mem_waitrequest = 1'b0;
        mem_readdatavalid = 1'b0;
        step();
        step();
        step();
        check("rst.busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        exp_data = '0;
        check_idle_outputs("rst_async");
        check("rst_async.mem_address", 32'(mem_address), 32'd0);
        address_enable = 1'b0;
        step();
        reset_n           = 1'b1;
        mem_readdatavalid = 1'b1;
        mem_readdata      = 32'h7777_7777;
        step();
        mem_readdatavalid = 1'b0;
        check_idle_outputs("rst_stray");
        run_txn(32'h0000_0300, 1, 2, 32'h8888_9999, 0, '0);

        for (int i = 0; i < 250; i++) begin
            regval_t a;
            a = $urandom;
            run_txn(a, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), $urandom,
                    int'($urandom_range(0, 3)), a ^ (32'h1 << $urandom_range(2, AW + 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
